// File: rtl/rtl_simd_addsub_stream_pkg.sv
// Shared definitions for the SIMD add/sub stream block.
// Holds default and maximum geometry, the control FSM encoding and the
// lane pack/unpack and signed-bound helpers used by the datapath.
package rtl_simd_addsub_stream_pkg;

    localparam int unsigned DEF_LANES      = 4;
    localparam int unsigned DEF_LANE_W     = 11;
    localparam int unsigned DEF_OBUF_DEPTH = 4;

    localparam int unsigned MAX_LANES   = 8;
    localparam int unsigned MAX_LANE_W  = 24;
    localparam int unsigned MAX_LANE_W1 = MAX_LANE_W + 1;
    localparam int unsigned MAX_BUS_W   = MAX_LANES * MAX_LANE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Low w bits set.
    function automatic logic [MAX_LANE_W-1:0] lane_mask(input int unsigned w);
        logic [MAX_LANE_W1-1:0] m;
        m = (MAX_LANE_W1'(1) << w) - MAX_LANE_W1'(1);
        return MAX_LANE_W'(m);
    endfunction

    // Largest positive value of a w-bit two's complement lane.
    function automatic logic [MAX_LANE_W-1:0] lane_smax(input int unsigned w);
        return lane_mask(w - 1);
    endfunction

    // Most negative value of a w-bit two's complement lane (only bit w-1 set).
    function automatic logic [MAX_LANE_W-1:0] lane_smin(input int unsigned w);
        return MAX_LANE_W'(MAX_LANE_W1'(1) << (w - 1));
    endfunction

    // Extract lane idx of width w from a packed bus.
    function automatic logic [MAX_LANE_W-1:0] lane_unpack(input logic [MAX_BUS_W-1:0] bus,
                                                          input int unsigned idx,
                                                          input int unsigned w);
        logic [MAX_BUS_W-1:0] s;
        s = bus >> (idx * w);
        return MAX_LANE_W'(s) & lane_mask(w);
    endfunction

    // Merge value v into lane idx of width w of a packed bus (lane assumed clear).
    function automatic logic [MAX_BUS_W-1:0] lane_pack(input logic [MAX_BUS_W-1:0] bus,
                                                       input logic [MAX_LANE_W-1:0] v,
                                                       input int unsigned idx,
                                                       input int unsigned w);
        return bus | (MAX_BUS_W'(v & lane_mask(w)) << (idx * w));
    endfunction

endpackage

// File: rtl/rtl_stream_fwft_fifo.sv
// First-word-fall-through FIFO used as the credit-limited output buffer.
// Ports: clk/rst_n (async active-low), i_push/i_data write side,
// i_pop read side, o_data head entry (valid while !o_empty), o_empty,
// o_count occupancy. Push into a full FIFO is accepted only together
// with a pop in the same cycle; pop on empty is ignored.
module rtl_stream_fwft_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & ((r_count != CW'(DEPTH)) | w_do_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/rtl_simd_addsub_stream.sv
// Per-lane signed SIMD add/subtract over FIFO streams with block control.
// Ports: ap_clk, ap_rst_n (async active-low), ap_ce clock enable,
// ap_start/ap_done/ap_idle/ap_ready block control, op_sub selects a-b,
// a_*/b_* operand FIFO read sides, z_* result FIFO write side with
// per-lane overflow flags in z_ovf.
module rtl_simd_addsub_stream
    import rtl_simd_addsub_stream_pkg::*;
#(
    parameter int unsigned LANES      = DEF_LANES,
    parameter int unsigned LANE_W     = DEF_LANE_W,
    parameter int unsigned SATURATE   = 0,
    parameter int unsigned OBUF_DEPTH = DEF_OBUF_DEPTH
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    ap_ce,
    input  logic                    ap_start,
    output logic                    ap_done,
    output logic                    ap_idle,
    output logic                    ap_ready,
    input  logic                    op_sub,
    input  logic [LANES*LANE_W-1:0] a_dout,
    input  logic                    a_empty_n,
    output logic                    a_read,
    input  logic [LANES*LANE_W-1:0] b_dout,
    input  logic                    b_empty_n,
    output logic                    b_read,
    output logic [LANES*LANE_W-1:0] z_din,
    output logic [LANES-1:0]        z_ovf,
    input  logic                    z_full_n,
    output logic                    z_write
);

    localparam int unsigned BUS_W = LANES * LANE_W;
    localparam int unsigned ENT_W = BUS_W + LANES;
    localparam int unsigned CNT_W = $clog2(OBUF_DEPTH + 1);

    if (OBUF_DEPTH < 3) begin : g_bad_depth
        $error("rtl_simd_addsub_stream: OBUF_DEPTH must be >= 3");
    end
    if (LANES < 1 || LANES > MAX_LANES) begin : g_bad_lanes
        $error("rtl_simd_addsub_stream: LANES must be 1..8");
    end
    if (LANE_W < 2 || LANE_W > MAX_LANE_W) begin : g_bad_lane_w
        $error("rtl_simd_addsub_stream: LANE_W must be 2..24");
    end

    state_e             r_state;
    state_e             w_state_nxt;

    logic               r_s1_vld;
    logic [BUS_W-1:0]   r_s1_a;
    logic [BUS_W-1:0]   r_s1_b;
    logic               r_s1_sub;
    logic               r_s2_vld;
    logic [BUS_W-1:0]   r_s2_res;
    logic [LANES-1:0]   r_s2_ovf;

    logic [BUS_W-1:0]   w_res_bus;
    logic [LANES-1:0]   w_ovf;
    logic [1:0]         w_inflight;
    logic               w_credit_ok;
    logic               w_accept;
    logic               w_fifo_empty;
    logic [CNT_W-1:0]   w_fifo_count;
    logic [ENT_W-1:0]   w_fifo_head;

    // Credit check: every accepted pair already owns an obuf slot, so the
    // S2 push can never find the buffer full without a matching pop.
    assign w_inflight  = {1'b0, r_s1_vld} + {1'b0, r_s2_vld};
    assign w_credit_ok = (32'(w_fifo_count) + 32'(w_inflight)) < OBUF_DEPTH;
    assign w_accept    = ap_ce & ap_start & a_empty_n & b_empty_n & w_credit_ok
                       & (r_state != ST_DRAIN);

    assign a_read   = w_accept;
    assign b_read   = w_accept;
    assign ap_ready = w_accept;
    assign ap_idle  = (r_state == ST_IDLE) & ~ap_start;
    assign z_write  = ap_ce & z_full_n & ~w_fifo_empty;
    assign ap_done  = z_write;
    assign z_din    = w_fifo_empty ? '0 : w_fifo_head[BUS_W-1:0];
    assign z_ovf    = w_fifo_empty ? '0 : w_fifo_head[ENT_W-1:BUS_W];

    // Control FSM state register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= ST_IDLE;
        end else if (ap_ce) begin
            r_state <= w_state_nxt;
        end
    end

    // Control FSM next state.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (ap_start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!ap_start) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (ap_start) begin
                    w_state_nxt = ST_RUN;
                end else if ((w_inflight == 2'd0) && w_fifo_empty) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Per-lane arithmetic in LANE_W+1 bits; overflow when the two top bits differ.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [LANE_W-1:0] w_a;
        logic [LANE_W-1:0] w_b;
        logic [LANE_W:0]   w_ext;
        logic              w_of;

        assign w_a   = LANE_W'(lane_unpack(MAX_BUS_W'(r_s1_a), gi, LANE_W));
        assign w_b   = LANE_W'(lane_unpack(MAX_BUS_W'(r_s1_b), gi, LANE_W));
        assign w_ext = r_s1_sub ? ({w_a[LANE_W-1], w_a} - {w_b[LANE_W-1], w_b})
                                : ({w_a[LANE_W-1], w_a} + {w_b[LANE_W-1], w_b});
        assign w_of  = w_ext[LANE_W] ^ w_ext[LANE_W-1];
        assign w_ovf[gi] = w_of;

        if (SATURATE != 0) begin : g_sat
            // Top bit of the extended result is the sign of the true value.
            assign w_res_bus[gi*LANE_W +: LANE_W] =
                !w_of        ? w_ext[LANE_W-1:0] :
                w_ext[LANE_W] ? LANE_W'(lane_smin(LANE_W)) : LANE_W'(lane_smax(LANE_W));
        end else begin : g_wrap
            assign w_res_bus[gi*LANE_W +: LANE_W] = w_ext[LANE_W-1:0];
        end
    end

    // S1 operand capture and S2 result register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_sub <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s2_res <= '0;
            r_s2_ovf <= '0;
        end else if (ap_ce) begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_a   <= a_dout;
                r_s1_b   <= b_dout;
                r_s1_sub <= op_sub;
            end
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_res <= w_res_bus;
                r_s2_ovf <= w_ovf;
            end
        end
    end

    rtl_stream_fwft_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .i_push  (ap_ce & r_s2_vld),
        .i_data  ({r_s2_ovf, r_s2_res}),
        .i_pop   (z_write),
        .o_data  (w_fifo_head),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

endmodule

// File: doc/rtl_simd_addsub_stream.md
Name: rtl_simd_addsub_stream

Overview:
Parametrised successor to the fixed 4x11-bit SIMD stream adder. It performs a per-lane signed add or subtract of LANES packed operands. Wrap or saturating arithmetic is selectable, and per-lane overflow flags are produced. Unlike the previous block, it honours full FIFO-stream handshakes on both inputs and the output, including real backpressure via a credit-limited output buffer. It is a black-box RTL IP instantiated by HLS top-levels under ap_ctrl_hs-style block control, with SIMD packing intended for DSP inference.

Parameters:
LANES, 4, number of packed lanes (1..8)
LANE_W, 11, bits per lane, two's complement (2..24)
SATURATE, 0, 0 = wrap on overflow, 1 = clamp to signed min/max
OBUF_DEPTH, 4, output buffer entries; must be >= 3 (elaboration error otherwise)

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous, active-low reset
ap_ce  in  1  clock enable; low freezes all state, strobes forced low
ap_start  in  1  run request, level
ap_done  out  1  pulses with each z_write
ap_idle  out  1  no work in flight and ap_start low
ap_ready  out  1  pulses when an operand pair is consumed
op_sub  in  1  0 = a+b, 1 = a-b; sampled with operands
a_dout  in  LANES*LANE_W  operand A; lane i = bits [i*LANE_W +: LANE_W]
a_empty_n  in  1  A valid
a_read  out  1  A pop
b_dout  in  LANES*LANE_W  operand B
b_empty_n  in  1  B valid
b_read  out  1  B pop
z_din  out  LANES*LANE_W  result
z_ovf  out  LANES  per-lane overflow, aligned with z_din
z_full_n  in  1  sink not full
z_write  out  1  push strobe

Behaviour:
- Reset (async assert, sync release): all outputs and registers 0, except ap_idle = 1. FSM goes to IDLE, buffer is emptied, in-flight work is discarded. Reset mid-stream drops all results and asserts no strobes.
- Accept condition: accept = ap_ce & ap_start & a_empty_n & b_empty_n & (obuf_count + inflight < OBUF_DEPTH).
  - a_read = b_read = ap_ready = accept.
  - The inputs are never popped singly.
- Pipeline, gated by ap_ce:
  - S1 registers operands and op_sub on accept.
  - S2 computes per lane in LANE_W+1 bits, derives overflow, applies wrap or saturation, then pushes into obuf.
  - obuf is first-word-fall-through. z_write = ap_ce & z_full_n & obuf non-empty; z_din and z_ovf show the head entry.
  - Unstalled latency: accept in cycle t, z_write in cycle t+3.
- Arithmetic:
  - Overflow occurs when the true sum or difference lies outside [-2^(LANE_W-1), 2^(LANE_W-1)-1].
  - In wrap mode, the result is the low LANE_W bits. In saturate mode, it clamps to the bound in the sign direction.
  - z_ovf[i] is set on overflow in either mode.
  - Lanes are independent; no carries cross lane boundaries.
- Credits: inflight counts S1+S2 valid (0..2). Acceptance stops so that obuf can never overflow; no result is ever lost or duplicated.
- FSM:
  - IDLE: ap_idle = 1. Goes to RUN on ap_start.
  - RUN: accepts per the accept rule. Goes to DRAIN when ap_start drops.
  - DRAIN: no accepts. Goes back to RUN on ap_start; goes to IDLE when inflight == 0, obuf is empty and ap_start is low.
- Simultaneous push and pop on obuf: count unchanged; order is strictly FIFO.
- Full obuf with z_full_n high: a pop and a push in the same cycle are both legal.
- ap_continue is not used. ap_done = z_write.

Decomposition:
- Shared package: lane-width/lane-count localparams, signed min/max constants, FSM state enum, and pack/unpack lane functions.
- One sub-module, rtl_stream_fwft_fifo (WIDTH, DEPTH), used for obuf.

Test Plan:
- Add, wrap mode, LANES=4, LANE_W=11: a lanes {5, -3, 100, 0}, b lanes {7, 3, -200, 0} -> z {12, 0, -100, 0}, z_ovf=0, z_write 3 cycles after a_read.
- Wrap overflow: lane0 1023+1 -> z lane0 = -1024 (0x400), z_ovf[0]=1. With SATURATE=1 -> 1023 (0x3FF), z_ovf[0]=1.
- Subtract, saturate: op_sub=1, lane1 -1024-1 -> -1024, z_ovf[1]=1. 5-9 -> -4, z_ovf[1]=0.
- Backpressure: z_full_n low, 8 pairs offered -> exactly 4 accepts then a_read stays low. On z_full_n high, all 8 results emerge in order and ap_idle goes 1 after the last.
- ap_ce low for 5 cycles mid-stream -> no strobes, state frozen, stream resumes with no loss.
- ap_rst_n pulsed low with 3 results pending -> outputs zero immediately, ap_idle=1, no z_write afterwards.
